// File: rtl/cdb_writeback.sv
// cdb_writeback: Common Data Bus arbiter and register-status (Qi) stage.
// Buffers add/mul results in small FIFOs, grants one head per cycle onto the
// CDB, and writes the register bank only when the broadcast tag still owns
// its destination register.
// Optional feature macro: CDB_ROUND_ROBIN_EN (round-robin grant between the
// two units). When undefined, mul always has priority over add.
//
// Handshake: a unit transfers a result on the rising edge where both
// <unit>_valid and <unit>_ready are high. ready depends only on buffer
// occupancy and reset, never on valid, and the unit must hold tag/data
// stable while valid is high and ready is low.
module cdb_writeback #(
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 3,
  parameter int NREG       = 7,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [2:0]            issue_dest,
  input  logic [TAG_W-1:0]      issue_tag,
  input  logic                  add_valid,
  input  logic [TAG_W-1:0]      add_tag,
  input  logic [DATA_W-1:0]     add_data,
  input  logic                  mul_valid,
  input  logic [TAG_W-1:0]      mul_tag,
  input  logic [DATA_W-1:0]     mul_data,
  output logic                  add_ready,
  output logic                  mul_ready,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [DATA_W-1:0]     cdb_data,
  output logic                  rf_write,
  output logic [2:0]            rf_address,
  output logic [DATA_W-1:0]     rf_data,
  output logic [NREG*TAG_W-1:0] qi_flat
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int UA    = 0;  // add unit slot
  localparam int UM    = 1;  // mul unit slot

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Per-unit buffers
  entry_t           mem_q    [2][FIFO_DEPTH];
  entry_t           mem_d    [2][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_d [2];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [CNT_W-1:0] cnt_q    [2];
  logic [CNT_W-1:0] cnt_d    [2];

  // Register status and registered bus outputs
  logic [TAG_W-1:0]  qi_q [1:NREG];
  logic [TAG_W-1:0]  qi_d [1:NREG];
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              rf_write_q, rf_write_d;
  logic [2:0]        rf_address_q, rf_address_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

`ifdef CDB_ROUND_ROBIN_EN
  // 1 = mul wins the next tie; flips away from whichever unit was granted.
  logic favor_mul_q, favor_mul_d;
`endif

  logic   in_valid  [2];
  entry_t in_entry  [2];
  logic   buf_ready [2];
  logic   buf_empty [2];
  logic   push      [2];
  entry_t head      [2];
  logic   grant     [2];
  logic   grant_any;
  entry_t gnt_entry;

  logic       match_hit;
  logic [2:0] match_idx;
  logic       issue_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Buffer status: occupancy, head entry, ready and push qualification
  always_comb begin
    in_valid[UA]      = add_valid;
    in_valid[UM]      = mul_valid;
    in_entry[UA].tag  = add_tag;
    in_entry[UA].data = add_data;
    in_entry[UM].tag  = mul_tag;
    in_entry[UM].data = mul_data;
    for (int u = 0; u < 2; u++) begin
      buf_empty[u] = (cnt_q[u] == '0);
      buf_ready[u] = (cnt_q[u] != CNT_W'(FIFO_DEPTH)) && !reset;
      head[u]      = mem_q[u][rd_ptr_q[u]];
      push[u]      = in_valid[u] && (cnt_q[u] != CNT_W'(FIFO_DEPTH)) && !reset;
    end
  end

  assign add_ready = buf_ready[UA];
  assign mul_ready = buf_ready[UM];

  // Arbitration: pick at most one non-empty head per cycle
  always_comb begin
    grant[UA] = 1'b0;
    grant[UM] = 1'b0;
`ifdef CDB_ROUND_ROBIN_EN
    if (!buf_empty[UA] && !buf_empty[UM]) begin
      grant[UM] = favor_mul_q;
      grant[UA] = !favor_mul_q;
    end else begin
      grant[UM] = !buf_empty[UM];
      grant[UA] = !buf_empty[UA];
    end
    favor_mul_d = favor_mul_q;
    if (grant[UA]) begin
      favor_mul_d = 1'b1;
    end else if (grant[UM]) begin
      favor_mul_d = 1'b0;
    end
`else
    grant[UM] = !buf_empty[UM];
    grant[UA] = !buf_empty[UA] && buf_empty[UM];
`endif
    grant_any = grant[UA] || grant[UM];
    gnt_entry = grant[UM] ? head[UM] : head[UA];
  end

  // Buffer next state: push at the write pointer, pop the granted head
  always_comb begin
    mem_d = mem_q;
    for (int u = 0; u < 2; u++) begin
      rd_ptr_d[u] = rd_ptr_q[u];
      wr_ptr_d[u] = wr_ptr_q[u];
      if (push[u]) begin
        mem_d[u][wr_ptr_q[u]] = in_entry[u];
        wr_ptr_d[u]           = next_ptr(wr_ptr_q[u]);
      end
      if (grant[u]) begin
        rd_ptr_d[u] = next_ptr(rd_ptr_q[u]);
      end
      cnt_d[u] = cnt_q[u] + CNT_W'(push[u]) - CNT_W'(grant[u]);
    end
  end

  // Writeback: broadcast, Qi ownership check, issue rename (issue wins)
  always_comb begin
    match_hit = 1'b0;
    match_idx = 3'd0;
    for (int r = 1; r <= NREG; r++) begin
      if (grant_any && (gnt_entry.tag != '0) && (qi_q[r] == gnt_entry.tag)) begin
        match_hit = 1'b1;
        match_idx = 3'(r);
      end
    end
    issue_ok = issue_valid && (issue_dest != 3'd0) && (issue_tag != '0);

    qi_d = qi_q;
    if (match_hit) begin
      qi_d[match_idx] = '0;
    end
    if (issue_ok) begin
      qi_d[issue_dest] = issue_tag;
    end

    cdb_valid_d  = grant_any;
    cdb_tag_d    = grant_any ? gnt_entry.tag  : cdb_tag_q;
    cdb_data_d   = grant_any ? gnt_entry.data : cdb_data_q;
    // A re-issue of the same register this cycle makes the result stale.
    rf_write_d   = match_hit && !(issue_ok && (issue_dest == match_idx));
    rf_address_d = rf_write_d ? match_idx      : rf_address_q;
    rf_data_d    = rf_write_d ? gnt_entry.data : rf_data_q;
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int u = 0; u < 2; u++) begin
        rd_ptr_q[u] <= '0;
        wr_ptr_q[u] <= '0;
        cnt_q[u]    <= '0;
      end
      for (int r = 1; r <= NREG; r++) begin
        qi_q[r] <= '0;
      end
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
      rf_write_q   <= 1'b0;
      rf_address_q <= 3'd0;
      rf_data_q    <= '0;
`ifdef CDB_ROUND_ROBIN_EN
      favor_mul_q  <= 1'b1;
`endif
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      qi_q         <= qi_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_data_q   <= cdb_data_d;
      rf_write_q   <= rf_write_d;
      rf_address_q <= rf_address_d;
      rf_data_q    <= rf_data_d;
`ifdef CDB_ROUND_ROBIN_EN
      favor_mul_q  <= favor_mul_d;
`endif
    end
  end

  // Buffer storage; entries are only meaningful below the occupancy count
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Flatten Qi with R1 in the low bits
  always_comb begin
    qi_flat = '0;
    for (int r = 1; r <= NREG; r++) begin
      qi_flat[(r-1)*TAG_W +: TAG_W] = qi_q[r];
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_data   = cdb_data_q;
  assign rf_write   = rf_write_q;
  assign rf_address = rf_address_q;
  assign rf_data    = rf_data_q;

endmodule

// File: doc/cdb_writeback.md
# cdb_writeback

Common Data Bus arbiter and register-status stage that feeds the 7-entry, 16-bit register bank. Takes completed results from the add and multiply functional units, buffers them, grants one result per cycle onto the CDB, and tracks each register's producing tag (Qi). A broadcast drives the bank's single write port only when its tag still owns the destination register.

## Interface
- DATA_W, 16, result and register width
- TAG_W, 3, reservation-station tag width; tag 0 means "no producer"
- NREG, 7, architectural registers R1..R7; register address 0 is never written
- FIFO_DEPTH, 2, entries per functional-unit input buffer
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  issue stage renames a destination this cycle
- issue_dest  in  3  destination register (1..7; 0 ignored)
- issue_tag  in  TAG_W  producing tag (0 ignored)
- add_valid / mul_valid  in  1  unit presents a result
- add_tag / mul_tag  in  TAG_W  result tag
- add_data / mul_data  in  DATA_W  result value
- add_ready / mul_ready  out  1  input buffer not full; transfer on valid&&ready
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast value
- rf_write  out  1  to bank write
- rf_address  out  3  to bank address
- rf_data  out  DATA_W  to bank data
- qi_flat  out  NREG*TAG_W  Qi of R1..R7, R1 in the low bits

## Operation
- Each unit has its own FIFO_DEPTH-entry FIFO. Push on valid&&ready. Ready = not full, forced 0 while reset is high.
- Arbitration is combinational over the non-empty FIFO heads. At most one head is granted and popped per cycle.
- On grant, the following are registered: cdb_valid=1, cdb_tag and cdb_data from the granted head.
- Qi match: find r with Qi[r]==granted tag (nonzero). Tags are unique, so there is at most one match.
  - If a match exists: clear Qi[r] to 0, and register rf_write=1, rf_address=r, rf_data=granted data.
  - If no match: rf_write=0. The result is still broadcast for the reservation stations.
- Issue (issue_valid, dest≠0, tag≠0) sets Qi[dest]=issue_tag.
- Simultaneous issue and match on the same register: issue wins. Qi[dest] takes the new tag and rf_write is suppressed, because the result is stale.
- Simultaneous issue and match on different registers: both take effect.
- No grant: cdb_valid=0 and rf_write=0. rf_address and rf_data hold their last values.
- Full FIFO: ready=0, even if a pop occurs in the same cycle.
- Empty FIFO: not eligible for a grant.

## Timing
- Reset values: all FIFOs empty; Qi all 0 (qi_flat=0); cdb_valid=0, cdb_tag=0, cdb_data=0; rf_write=0, rf_address=0, rf_data=0; add_ready=0 and mul_ready=0 during reset, 1 on the first cycle after.
- Latency, uncontended: handshake in cycle N → FIFO head in N+1 → grant in N+1 → cdb and rf outputs valid in N+2. The bank then writes at the edge ending N+2.
- Throughput: one broadcast per cycle sustained while any FIFO is non-empty.
- Qi update is visible on qi_flat the cycle after the grant or issue edge.
- Reset mid-operation: buffered results are discarded, and all outputs take their reset values on the next edge.

## Configuration
- CDB_ROUND_ROBIN_EN defined: round-robin grant. A one-bit last-grant pointer points away from the unit granted last; the pointer resets to favour mul first.
- Undefined: fixed priority, mul over add. add can starve while mul is continuously non-empty.

## Test plan
- Reset, then issue R4←tag 3. Push add tag 3 data 0x00AA in cycle N → in N+2 cdb_valid=1, tag=3, rf_write=1, rf_address=4, rf_data=0x00AA; Qi[R4]=0 afterwards.
- Issue R2←tag 5, then R2←tag 6. Push tag 5 data 0x1111 → cdb broadcasts tag 5, rf_write=0, Qi[R2] stays 6.
- Issue R1←tag 1 in the same cycle that tag 1 (an earlier producer with Qi[R1]=1) is granted → Qi[R1]=1 (new), rf_write=0.
- add and mul both valid every cycle, distinct tags. With CDB_ROUND_ROBIN_EN: grants alternate mul, add, mul, ... Without the macro: only mul is granted until mul_valid drops.
- Hold the CDB busy until the add FIFO holds 2 entries → add_ready=0. A third push is refused and its data is not lost at the source.
- Fill both FIFOs and set Qi entries, assert reset for one cycle → cdb_valid=0, rf_write=0, qi_flat=0, FIFOs empty, readies 1 on the following cycle.
